// File: rtl/mem_stage_dbus.sv
// mem_stage_dbus -- MEM-stage data bus for the 5-stage MIPS32 pipeline.
// Decodes the EX/MEM byte address into data RAM or the peripheral window.
// The peripherals are a reloadable timer (TH/TL/TCON) with an interrupt, LEDs
// and the 7-segment display register. Loads return data combinationally so
// MEM/WB can capture it on the same edge. Stores commit on the rising edge.
//
// Optional build macro: MEM_DBUS_SYSTICK_EN
//   When defined, MMIO_BASE+0x14 is a read-only free-running 32-bit cycle counter.
//   When undefined, no counter exists and that address reads as unmapped (0).
module mem_stage_dbus #(
    parameter int          RAM_DEPTH = 512,
    parameter logic [31:0] MMIO_BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_MEM_MemRd,
    input  logic        EX_MEM_MemWr,
    input  logic [31:0] EX_MEM_ALUOut,
    input  logic [31:0] EX_MEM_WrData,
    output logic [31:0] MemRdData,
    output logic [7:0]  leds,
    output logic [11:0] digi,
    output logic        irq
);

    // ------------------------------------------------------------------
    // Address map constants
    // ------------------------------------------------------------------
    localparam int AW          = $clog2(RAM_DEPTH);
    localparam int N_MMIO      = 6;
    localparam int SEL_TH      = 0;
    localparam int SEL_TL      = 1;
    localparam int SEL_TCON    = 2;
    localparam int SEL_LEDS    = 3;
    localparam int SEL_DIGI    = 4;
    localparam int SEL_SYSTICK = 5;

    localparam logic [29:0] MMIO_WORD = MMIO_BASE[31:2];
    localparam logic [31:0] TL_MAX    = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // Byte lane bits are ignored: every access is treated as word aligned.
    logic [29:0]       w_word_addr;
    logic [AW-1:0]     w_ram_idx;
    logic              w_sel_ram;
    logic [N_MMIO-1:0] w_sel_mmio;
    logic              w_wr_ok;
    logic              w_we_ram;
    logic [N_MMIO-1:0] w_we_mmio;

    assign w_word_addr = EX_MEM_ALUOut[31:2];
    assign w_ram_idx   = EX_MEM_ALUOut[AW+1:2];

    // RAM occupies 0 .. RAM_DEPTH*4-1, so all bits above the index must be zero.
    assign w_sel_ram   = (EX_MEM_ALUOut[31:AW+2] == '0);

    // Stores are dropped while reset is asserted, for RAM as well as peripherals.
    assign w_wr_ok     = EX_MEM_MemWr & ~rst;
    assign w_we_ram    = w_wr_ok & w_sel_ram;

    // One select and one write strobe per consecutive peripheral word.
    genvar gi;
    generate
        for (gi = 0; gi < N_MMIO; gi++) begin : g_mmio_dec
            assign w_sel_mmio[gi] = (w_word_addr == (MMIO_WORD + 30'(gi)));
            assign w_we_mmio[gi]  = w_wr_ok & w_sel_mmio[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Data RAM (contents survive reset; read is asynchronous)
    // ------------------------------------------------------------------
    logic [31:0] r_ram [RAM_DEPTH];

    // Commit stores to the data RAM.
    always_ff @(posedge clk) begin
        if (w_we_ram) begin
            r_ram[w_ram_idx] <= EX_MEM_WrData;
        end
    end

    // ------------------------------------------------------------------
    // Peripheral registers
    // ------------------------------------------------------------------
    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [7:0]  r_leds;
    logic [11:0] r_digi;

    logic [31:0] w_tl_next;
    logic [2:0]  w_tcon_next;
    logic        w_tl_wrap;

    // Timer next state: count or reload, then let a CPU store override.
    always_comb begin
        w_tl_next   = r_tl;
        w_tcon_next = r_tcon;
        w_tl_wrap   = r_tcon[0] && (r_tl == TL_MAX);

        if (r_tcon[0]) begin
            if (w_tl_wrap) begin
                // Reload uses the TH value held before this edge.
                w_tl_next = r_th;
                if (r_tcon[1]) begin
                    w_tcon_next[2] = 1'b1;
                end
            end else begin
                w_tl_next = r_tl + 32'd1;
            end
        end

        // A CPU store to TL or TCON wins over the timer in the same cycle;
        // a TCON store during an overflow therefore drops that status set.
        if (w_we_mmio[SEL_TL]) begin
            w_tl_next = EX_MEM_WrData;
        end
        if (w_we_mmio[SEL_TCON]) begin
            w_tcon_next = EX_MEM_WrData[2:0];
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tl   <= '0;
            r_tcon <= '0;
        end else begin
            r_tl   <= w_tl_next;
            r_tcon <= w_tcon_next;
        end
    end

    // Timer reload value, written only by software.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_th <= '0;
        end else if (w_we_mmio[SEL_TH]) begin
            r_th <= EX_MEM_WrData;
        end
    end

    // LED register keeps the low 8 bits of the stored word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds <= '0;
        end else if (w_we_mmio[SEL_LEDS]) begin
            r_leds <= EX_MEM_WrData[7:0];
        end
    end

    // Display register keeps anode select [11:8] and segments [7:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digi <= '0;
        end else if (w_we_mmio[SEL_DIGI]) begin
            r_digi <= EX_MEM_WrData[11:0];
        end
    end

`ifdef MEM_DBUS_SYSTICK_EN
    // ------------------------------------------------------------------
    // Free-running cycle counter (read-only; stores are ignored)
    // ------------------------------------------------------------------
    logic [31:0] r_systick;

    // Count every non-reset cycle, wrapping naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    // The systick write strobe is deliberately unused: the counter is read-only.
    logic w_unused;
    assign w_unused = &{1'b0, EX_MEM_ALUOut[1:0], w_we_mmio[SEL_SYSTICK]};
`else
    // Without the counter, the systick word decodes to nothing at all.
    logic w_unused;
    assign w_unused = &{1'b0, EX_MEM_ALUOut[1:0], w_we_mmio[SEL_SYSTICK],
                        w_sel_mmio[SEL_SYSTICK]};
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_rd_data;

    // Select the load data; zero when no load or when the address is unmapped.
    // State is read before the edge, so a load+store pair returns the old value.
    always_comb begin
        w_rd_data = '0;
        if (EX_MEM_MemRd) begin
            if (w_sel_ram) begin
                w_rd_data = r_ram[w_ram_idx];
            end else if (w_sel_mmio[SEL_TH]) begin
                w_rd_data = r_th;
            end else if (w_sel_mmio[SEL_TL]) begin
                w_rd_data = r_tl;
            end else if (w_sel_mmio[SEL_TCON]) begin
                w_rd_data = {29'd0, r_tcon};
            end else if (w_sel_mmio[SEL_LEDS]) begin
                w_rd_data = {24'd0, r_leds};
            end else if (w_sel_mmio[SEL_DIGI]) begin
                w_rd_data = {20'd0, r_digi};
`ifdef MEM_DBUS_SYSTICK_EN
            end else if (w_sel_mmio[SEL_SYSTICK]) begin
                w_rd_data = r_systick;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign MemRdData = w_rd_data;
    assign leds      = r_leds;
    assign digi      = r_digi;
    // Interrupt follows the registered TCON, so it rises the cycle after overflow.
    assign irq       = r_tcon[1] & r_tcon[2];

endmodule

// File: tb/tb_mem_stage_dbus.sv
// tb_mem_stage_dbus -- self-checking bench for mem_stage_dbus.
// A behavioural model (plain variables and arrays) tracks the address map,
// timer and optional systick; a negedge process compares every cycle, and a
// directed prologue pins the model with hand-computed literal values before
// a randomized phase.
module tb_mem_stage_dbus;

    localparam int          RAM_DEPTH = 512;
    localparam logic [31:0] MB        = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd  = 1'b0;
    logic        wr  = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] MemRdData;
    logic [7:0]  leds;
    logic [11:0] digi;
    logic        irq;

    mem_stage_dbus #(.RAM_DEPTH(RAM_DEPTH), .MMIO_BASE(MB)) dut (
        .clk           (clk),
        .rst           (rst),
        .EX_MEM_MemRd  (rd),
        .EX_MEM_MemWr  (wr),
        .EX_MEM_ALUOut (addr),
        .EX_MEM_WrData (wdata),
        .MemRdData     (MemRdData),
        .leds          (leds),
        .digi          (digi),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model state ----------------
    logic [31:0] m_ram [RAM_DEPTH];
    bit          m_ok  [RAM_DEPTH];
    logic [31:0] m_th, m_tl, m_systick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_leds;
    logic [11:0] m_digi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected load data for the current inputs: {known, value}.
    function automatic logic [32:0] model_read();
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if (!rd) return {1'b1, 32'd0};
        if (a < 32'(RAM_DEPTH * 4)) return {m_ok[a / 4], m_ram[a / 4]};
        case (a - MB)
            32'h00:  return {1'b1, m_th};
            32'h04:  return {1'b1, m_tl};
            32'h08:  return {1'b1, 29'd0, m_tcon};
            32'h0C:  return {1'b1, 24'd0, m_leds};
            32'h10:  return {1'b1, 20'd0, m_digi};
`ifdef MEM_DBUS_SYSTICK_EN
            32'h14:  return {1'b1, m_systick};
`endif
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Advance the model across one rising edge using the held inputs.
    task automatic model_step();
        logic [31:0] a;
        logic [31:0] ntl;
        logic [2:0]  ntc;
        if (rst) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_leds = 0; m_digi = 0; m_systick = 0;
        end else begin
            ntl = m_tl;
            ntc = m_tcon;
            if (m_tcon[0]) begin
                if (m_tl == 32'hFFFF_FFFF) begin
                    ntl = m_th;
                    if (m_tcon[1]) ntc[2] = 1'b1;
                end else begin
                    ntl = m_tl + 1;
                end
            end
            m_systick = m_systick + 1;
            if (wr) begin
                a = {addr[31:2], 2'b00};
                if (a < 32'(RAM_DEPTH * 4)) begin
                    m_ram[a / 4] = wdata;
                    m_ok[a / 4]  = 1'b1;
                end else begin
                    case (a - MB)
                        32'h00:  m_th   = wdata;
                        32'h04:  ntl    = wdata;
                        32'h08:  ntc    = wdata[2:0];
                        32'h0C:  m_leds = wdata[7:0];
                        32'h10:  m_digi = wdata[11:0];
                        default: ;
                    endcase
                end
            end
            m_tl   = ntl;
            m_tcon = ntc;
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic [32:0] e;
        if (chk_en) begin
            e = model_read();
            if (e[32]) check("MemRdData", MemRdData, e[31:0]);
            check("leds", {24'd0, leds}, {24'd0, m_leds});
            check("digi", {20'd0, digi}, {20'd0, m_digi});
            check("irq", {31'd0, irq}, {31'd0, (m_tcon[1] & m_tcon[2])});
        end
    end

    // One bus cycle: cross the edge, present new inputs, settle past negedge.
    task automatic cyc(input bit r_, input bit w_, input logic [31:0] a_,
                       input logic [31:0] d_, input bit rs_);
        @(posedge clk);
        model_step();
        #1;
        rd = r_; wr = w_; addr = a_; wdata = d_; rst = rs_;
        @(negedge clk);
        #1;
        $display("txn t=%0t rst=%0d rd=%0d wr=%0d addr=%08h wdata=%08h rdata=%08h leds=%02h digi=%03h irq=%0d",
                 $time, rst, rd, wr, addr, wdata, MemRdData, leds, digi, irq);
    endtask

    logic [31:0] s1, s2;

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) m_ok[i] = 1'b0;

        // Reset
        cyc(0, 0, 32'h0, 32'h0, 1);
        chk_en = 1'b1;
        cyc(0, 0, 32'h0, 32'h0, 1);
        check("rst_leds", {24'd0, leds}, 32'h0);
        check("rst_digi", {20'd0, digi}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        cyc(1, 0, MB + 32'h8, 32'h0, 0);
        check("rst_tcon_rd", MemRdData, 32'h0);

        // RAM store/load, unmapped load, ignored byte bits, read-during-write
        cyc(0, 1, 32'h10, 32'h1234_5678, 0);
        cyc(0, 1, 32'h14, 32'hCAFE_F00D, 0);
        cyc(1, 0, 32'h10, 32'h0, 0);
        check("ram_rd_10", MemRdData, 32'h1234_5678);
        cyc(1, 0, 32'h14, 32'h0, 0);
        check("ram_rd_14", MemRdData, 32'hCAFE_F00D);
        cyc(1, 0, 32'h3000_0000, 32'h0, 0);
        check("unmapped_rd", MemRdData, 32'h0);
        cyc(1, 0, 32'h13, 32'h0, 0);
        check("ram_rd_lowbits", MemRdData, 32'h1234_5678);
        cyc(1, 1, 32'h10, 32'hDEAD_BEEF, 0);
        check("rdwr_old", MemRdData, 32'h1234_5678);
        cyc(1, 0, 32'h10, 32'h0, 0);
        check("rdwr_new", MemRdData, 32'hDEAD_BEEF);

        // Timer overflow with interrupt enabled
        cyc(0, 1, MB + 32'h0, 32'hFFFF_FFFE, 0);
        cyc(0, 1, MB + 32'h4, 32'hFFFF_FFFE, 0);
        cyc(0, 1, MB + 32'h8, 32'h3, 0);
        cyc(1, 0, MB + 32'h4, 32'h0, 0);
        check("tl_start", MemRdData, 32'hFFFF_FFFE);
        cyc(1, 0, MB + 32'h4, 32'h0, 0);
        check("tl_max", MemRdData, 32'hFFFF_FFFF);
        cyc(1, 0, MB + 32'h8, 32'h0, 0);
        check("tcon_ovf", MemRdData, 32'h7);
        check("irq_set", {31'd0, irq}, 32'h1);
        check("model_tcon", {29'd0, m_tcon}, 32'h7);
        check("model_tl_reload", m_tl, 32'hFFFF_FFFE);
        cyc(1, 1, MB + 32'h8, 32'h3, 0);
        check("tcon_clr_old", MemRdData, 32'h7);
        cyc(1, 0, MB + 32'h8, 32'h0, 0);
        check("tcon_clr", MemRdData, 32'h3);
        check("irq_clr", {31'd0, irq}, 32'h0);
        cyc(1, 0, MB + 32'h4, 32'h0, 0);
        check("tl_after_clr", MemRdData, 32'hFFFF_FFFF);
        cyc(0, 1, MB + 32'h8, 32'h0, 0);

        // Timer overflow with interrupt disabled
        cyc(0, 1, MB + 32'h0, 32'h100, 0);
        cyc(0, 1, MB + 32'h4, 32'hFFFF_FFFF, 0);
        cyc(0, 1, MB + 32'h8, 32'h1, 0);
        cyc(1, 0, MB + 32'h4, 32'h0, 0);
        check("noirq_tl_max", MemRdData, 32'hFFFF_FFFF);
        cyc(1, 0, MB + 32'h4, 32'h0, 0);
        check("noirq_reload", MemRdData, 32'h100);
        cyc(1, 0, MB + 32'h8, 32'h0, 0);
        check("noirq_tcon", MemRdData, 32'h1);
        check("noirq_irq", {31'd0, irq}, 32'h0);

        // LEDs and display
        cyc(0, 1, MB + 32'hC, 32'h1A5, 0);
        cyc(0, 1, MB + 32'h10, 32'hF3C, 0);
        cyc(1, 0, MB + 32'hC, 32'h0, 0);
        check("leds_rd", MemRdData, 32'hA5);
        check("leds_port", {24'd0, leds}, 32'hA5);
        cyc(1, 0, MB + 32'h10, 32'h0, 0);
        check("digi_rd", MemRdData, 32'hF3C);
        check("digi_port", {20'd0, digi}, 32'hF3C);

        // Reset while counting, together with stores that must be dropped
        cyc(0, 1, MB + 32'h4, 32'h55, 1);
        cyc(1, 0, MB + 32'h4, 32'h0, 0);
        check("rst_tl", MemRdData, 32'h0);
        check("rst_leds2", {24'd0, leds}, 32'h0);
        check("rst_irq2", {31'd0, irq}, 32'h0);
        cyc(1, 0, MB + 32'h8, 32'h0, 0);
        check("rst_tcon2", MemRdData, 32'h0);
        cyc(0, 1, 32'h10, 32'h77, 1);
        cyc(1, 0, 32'h10, 32'h0, 0);
        check("rst_ram_blocked", MemRdData, 32'hDEAD_BEEF);

        // systick: loads six cycles apart, with an ignored store in between
        cyc(1, 0, MB + 32'h14, 32'h0, 0);
        s1 = MemRdData;
        for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 32'h0, 0);
        cyc(0, 1, MB + 32'h14, 32'h0, 0);
        cyc(1, 0, MB + 32'h14, 32'h0, 0);
        s2 = MemRdData;
`ifdef MEM_DBUS_SYSTICK_EN
        check("systick_delta", s2 - s1, 32'd6);
`else
        check("systick_absent1", s1, 32'h0);
        check("systick_absent2", s2, 32'h0);
`endif

        // Randomized phase, checked every cycle by the compare process
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] a, d;
            int k;
            k = $urandom_range(0, 9);
            if (k <= 3) begin
                a = ($urandom_range(0, 7) == 0) ? 32'((RAM_DEPTH - 1) * 4)
                                                : 32'($urandom_range(0, 15) * 4);
            end else if (k <= 7) begin
                a = MB + 32'($urandom_range(0, 7) * 4);
            end else if (k == 8) begin
                a = ($urandom_range(0, 1) == 0) ? 32'h3000_0000 : 32'(RAM_DEPTH * 4);
            end else begin
                a = MB + 32'h100;
            end
            a = a | 32'($urandom_range(0, 3));
            d = ($urandom_range(0, 3) == 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            if ((a & ~32'h3) == MB + 32'h8) d = 32'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
                ($urandom_range(0, 99) == 0));
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
